// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame state encoding and baud rounding.
// The receiver imports this too, so both ends of a link round the bit period identically.
package uart_pkg;

    localparam int PARITY_NONE = 32'sd0;
    localparam int PARITY_ODD  = 32'sd1;
    localparam int PARITY_EVEN = 32'sd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Rounded to nearest so the per-bit error stays within half a clock.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 32'sd2) / baud;
    endfunction

    function automatic logic parity_bit(input logic [7:0] dat, input logic odd);
        return odd ? ~(^dat) : (^dat);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Modulo-CLKS_PER_BIT bit-period counter; o_bit_end marks the last cycle of each bit.
// Wraps on its own so consecutive bits never accumulate drift.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_bit_end
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 32'sd1);

    logic [CW-1:0] cnt_r;

    // Count cycles within the current bit, restarting on clear or at the last cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
        end else if (i_clr || (cnt_r == LAST)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign o_bit_end = (cnt_r == LAST);

endmodule

// File: rtl/simple_uart_transmitter.sv
// UART transmitter: valid/ready byte input, one-byte holding register, 8 data bits LSB-first,
// optional parity and 1 or 2 stop bits; back-to-back frames leave no idle gap.
module simple_uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 250_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_dat,
    input  logic       i_dat_vld,
    output logic       o_dat_rdy,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

    if ((CLKS_PER_BIT < 32'sd2) || ((STOP_BITS != 32'sd1) && (STOP_BITS != 32'sd2))) begin : g_param_check
        $error("simple_uart_transmitter: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
    end

    uart_state_e state_r;
    logic        tx_r;
    logic [7:0]  shift_r;
    logic [2:0]  bit_idx_r;
    logic        stop_idx_r;
    logic        par_r;
    logic [7:0]  hold_dat_r;
    logic        hold_full_r;

    logic        accept_s;
    logic        load_s;
    logic        last_stop_s;
    logic        bit_end_s;
    logic        clr_s;

    // Counter is parked at zero while idle so a new start bit always gets a full period.
    assign clr_s = (state_r == ST_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (clr_s),
        .o_bit_end (bit_end_s)
    );

    // Handshake acceptance and the decision to pull the held byte into the shifter.
    always_comb begin
        accept_s    = i_dat_vld & ~hold_full_r;
        last_stop_s = (STOP_BITS == 32'sd1) ? 1'b1 : stop_idx_r;
        if (state_r == ST_IDLE) begin
            load_s = hold_full_r;
        end else if (state_r == ST_STOP) begin
            load_s = hold_full_r & bit_end_s & last_stop_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Frame FSM plus holding register; accept and load cannot coincide since accept needs it empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            tx_r        <= 1'b1;
            shift_r     <= 8'h00;
            bit_idx_r   <= 3'd0;
            stop_idx_r  <= 1'b0;
            par_r       <= 1'b0;
            hold_dat_r  <= 8'h00;
            hold_full_r <= 1'b0;
        end else begin
            if (accept_s) begin
                hold_dat_r  <= i_dat;
                hold_full_r <= 1'b1;
            end else if (load_s) begin
                hold_full_r <= 1'b0;
            end

            if (load_s) begin
                shift_r <= hold_dat_r;
                par_r   <= parity_bit(hold_dat_r, (PARITY == PARITY_ODD));
                tx_r    <= 1'b0;
                state_r <= ST_START;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        tx_r <= 1'b1;
                    end
                    ST_START: begin
                        if (bit_end_s) begin
                            tx_r      <= shift_r[0];
                            bit_idx_r <= 3'd0;
                            state_r   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end_s) begin
                            if (bit_idx_r == 3'd7) begin
                                if (PARITY != PARITY_NONE) begin
                                    tx_r    <= par_r;
                                    state_r <= ST_PARITY;
                                end else begin
                                    tx_r       <= 1'b1;
                                    stop_idx_r <= 1'b0;
                                    state_r    <= ST_STOP;
                                end
                            end else begin
                                shift_r   <= {1'b0, shift_r[7:1]};
                                tx_r      <= shift_r[1];
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end_s) begin
                            tx_r       <= 1'b1;
                            stop_idx_r <= 1'b0;
                            state_r    <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (bit_end_s) begin
                            if (last_stop_s) begin
                                tx_r    <= 1'b1;
                                state_r <= ST_IDLE;
                            end else begin
                                stop_idx_r <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        tx_r    <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_tx      = tx_r;
    assign o_dat_rdy = ~hold_full_r;
    assign o_busy    = (state_r != ST_IDLE) | hold_full_r;

endmodule

// File: tb/tb_simple_uart_transmitter.sv
// Bench for simple_uart_transmitter: three parity/stop configurations at 10 clocks per bit,
// checked cycle by cycle against a frame-level bit-list model and a mid-bit sampling receiver.
module tb_simple_uart_transmitter;

    localparam int CPB = 10;

    logic       clk;
    logic       rst_n;
    logic [7:0] dat  [3];
    logic       vld  [3];
    logic       tx   [3];
    logic       rdy  [3];
    logic       busy [3];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    simple_uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dat(dat[0]), .i_dat_vld(vld[0]),
        .o_dat_rdy(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]));

    simple_uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dat(dat[1]), .i_dat_vld(vld[1]),
        .o_dat_rdy(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]));

    simple_uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dat(dat[2]), .i_dat_vld(vld[2]),
        .o_dat_rdy(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent receiver: finds each start edge, samples mid-bit, compares decoded bytes.
    task automatic rx_decode(input int idx, input logic [7:0] bytes [$], input int fb, input int stops);
        logic [7:0] got;
        int         n;
        foreach (bytes[i]) begin
            n = 0;
            do begin @(posedge clk); #1; n++; end while ((tx[idx] !== 1'b0) && (n < 400));
            if (n >= 400) chk("rx_start_timeout", 8'd0, 8'd1);
            repeat (CPB / 2) begin @(posedge clk); #1; end
            chk("rx_start_mid", tx[idx], 1'b0);
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) begin @(posedge clk); #1; end
                got[j] = tx[idx];
            end
            repeat (CPB * (fb - 9 - stops)) begin @(posedge clk); #1; end
            repeat (CPB) begin @(posedge clk); #1; end
            chk("rx_stop_mid", tx[idx], 1'b1);
            chk("rx_byte", got, bytes[i]);
        end
    endtask

    // Send a byte list with i_dat_vld held, checking line, ready and busy every cycle.
    // Must be entered 1 time unit after a rising edge with the target instance idle.
    task automatic run_stream(input int idx, input logic [7:0] bytes [$], input bit do_rx);
        logic exp_bits [$];
        int   par;
        int   stops;
        int   nb;
        int   fb;
        int   flen;
        int   total;
        par   = (idx == 0) ? 0 : ((idx == 1) ? 2 : 1);
        stops = (idx == 2) ? 2 : 1;
        nb    = bytes.size();
        foreach (bytes[i]) begin
            exp_bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) exp_bits.push_back(bytes[i][j]);
            if (par == 2) exp_bits.push_back(($countones(bytes[i]) % 2) == 1);
            if (par == 1) exp_bits.push_back(($countones(bytes[i]) % 2) == 0);
            for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
        end
        fb    = exp_bits.size() / nb;
        flen  = fb * CPB;
        total = nb * flen;
        fork
            begin
                foreach (bytes[i]) begin
                    bit acc;
                    int n;
                    dat[idx] = bytes[i];
                    vld[idx] = 1'b1;
                    n = 0;
                    do begin acc = rdy[idx]; @(posedge clk); #1; n++; end while (!acc && (n < 1000));
                    if (!acc) chk("accept_timeout", 8'd0, 8'd1);
                end
                vld[idx] = 1'b0;
            end
            begin
                @(posedge clk); #1;
                chk("rdy_after_accept", rdy[idx], 1'b0);
                for (int k = 0; k < total; k++) begin
                    @(posedge clk); #1;
                    chk("tx_bit", tx[idx], exp_bits[k / CPB]);
                    chk("rdy", rdy[idx], ((k < (nb - 1) * flen) && ((k % flen) != 0)) ? 1'b0 : 1'b1);
                    chk("busy", busy[idx], 1'b1);
                end
                @(posedge clk); #1;
                chk("busy_end", busy[idx], 1'b0);
                chk("tx_idle_end", tx[idx], 1'b1);
            end
            begin
                if (do_rx) rx_decode(idx, bytes, fb, stops);
            end
        join
    endtask

    initial begin
        logic [7:0] q [$];
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_tx", tx[i], 1'b1);
            chk("rst_rdy", rdy[i], 1'b1);
            chk("rst_busy", busy[i], 1'b0);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk("post_rst_tx", tx[0], 1'b1);
            chk("post_rst_busy", busy[0], 1'b0);
        end

        q = {8'hA5};
        run_stream(0, q, 1'b0);
        q = {8'h55, 8'h0F};
        run_stream(0, q, 1'b0);
        q = {8'h07};
        run_stream(1, q, 1'b0);
        run_stream(2, q, 1'b0);

        // Abort a 0xFF frame during data bit 3, asynchronously between clock edges.
        dat[0] = 8'hFF;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        chk("bit3_busy", busy[0], 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_tx", tx[0], 1'b1);
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_rdy", rdy[0], 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("after_abort_tx", tx[0], 1'b1);
        end
        q = {8'h3C};
        run_stream(0, q, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int idx;
            int n;
            idx = int'($urandom_range(0, 2));
            n   = int'($urandom_range(1, 3));
            q   = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            run_stream(idx, q, 1'b1);
        end

        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        run_stream(0, q, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
